flip_flop_fifo_with_levels: RTL

Parametrised flip-flop FIFO with occupancy counter: next generation of the counter-based FIFO, adding arbitrary (non-power-of-two) depth, a live occupancy count, programmable almost-full/almost-empty thresholds, a push-when-full-with-pop mode and optional sticky overflow/underflow error flags. Sits between a producer and a consumer in the same clock domain as a show-ahead buffer. `read_data` shows the head entry combinationally.

---
 rtl/flip_flop_fifo_with_levels.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/flip_flop_fifo_with_levels.sv
// -----------------------------------------------------------------------------
// flip_flop_fifo_with_levels
//
// Show-ahead FIFO built from a flip-flop array. It supports any depth of 2 or
// more, keeps a live occupancy count and provides programmable almost-full and
// almost-empty thresholds. When allow_push_when_full_with_pop is 1, a push is
// accepted while full as long as a pop happens in the same cycle.
//
// Build option:
//   FIFO_ERROR_FLAGS_EN - when defined, builds sticky overflow/underflow flags.
//                         When undefined, both outputs are tied to 0.
//
// Parameters:
//   width                          data width in bits
//   depth                          number of entries (>= 2)
//   almost_full_level              almost_full when count >= level (1..depth)
//   almost_empty_level             almost_empty when count <= level (0..depth-1)
//   allow_push_when_full_with_pop  1: push accepted while full if pop is set
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   push         write request
//   pop          read/advance request
//   write_data   data stored on an accepted push
//   read_data    head entry (combinational), valid when empty = 0
//   empty        count == 0
//   full         count == depth
//   almost_empty count <= almost_empty_level
//   almost_full  count >= almost_full_level
//   count        current occupancy
//   overflow     sticky: a push was rejected
//   underflow    sticky: a pop was rejected
// -----------------------------------------------------------------------------
module flip_flop_fifo_with_levels #(
    parameter int unsigned width                         = 8,
    parameter int unsigned depth                         = 5,
    parameter int unsigned almost_full_level             = depth - 1,
    parameter int unsigned almost_empty_level            = 1,
    parameter bit          allow_push_when_full_with_pop = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           write_data,
    output logic [width-1:0]           read_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CW = $clog2(depth + 1);

    if (depth < 2) begin : g_bad_depth
        $error("flip_flop_fifo_with_levels: depth must be >= 2");
    end
    if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_af
        $error("flip_flop_fifo_with_levels: almost_full_level out of range");
    end
    if (almost_empty_level > depth - 1) begin : g_bad_ae
        $error("flip_flop_fifo_with_levels: almost_empty_level out of range");
    end

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(depth));
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | (allow_push_when_full_with_pop & pop));

    // Explicit wrap at depth-1; the pointers do not rely on a power-of-two depth.
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(depth - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(depth - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            // Simultaneous accepted push and pop leave the count unchanged.
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef FIFO_ERROR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign read_data    = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= CW'(almost_empty_level));
    assign almost_full  = (r_count >= CW'(almost_full_level));

endmodule
